// File: rtl/uart_rx_ctrl_pkg.sv
// uart_rx_ctrl_pkg: shared state encoding for the uart_rx handshake controller.
package uart_rx_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;
endpackage

// File: rtl/uart_rx_ctrl_byte_fifo.sv
// byte_fifo: first-word-fall-through byte FIFO with AW+1 bit pointers.
module byte_fifo #(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [7:0]    i_data,
  output logic [7:0]    o_data,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_fill
);
  logic [7:0]  r_mem [DEPTH];
  logic [AW:0] r_wr, r_rd;
  logic        w_push, w_pop;
  assign o_empty = r_wr == r_rd;
  assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign o_fill  = r_wr - r_rd;
  assign w_pop   = i_pop && !o_empty;
  // a pop in the same cycle frees the slot a full FIFO needs
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_data  = o_empty ? 8'h00 : r_mem[r_rd[AW-1:0]];
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      r_wr <= r_wr + (AW+1)'(w_push);
      r_rd <= r_rd + (AW+1)'(w_pop);
    end
  always_ff @(posedge i_clk)
    if (w_push) r_mem[r_wr[AW-1:0]] <= i_data;
endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: sequences the uart_rx ready handshake and buffers bytes in byte_fifo.
// Define UART_RX_CTRL_STATS_EN to add the saturating o_drop_cnt output.
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter  int DEPTH      = 16,
  parameter  int HS_TIMEOUT = 1023,
  localparam int AW         = $clog2(DEPTH),
  localparam int TW         = $clog2(HS_TIMEOUT + 1)
) (
  input  logic          i_uart_clk,
  input  logic          i_rst_n,
  input  logic [7:0]    i_rx_byte,
  input  logic          i_rx_valid,
  input  logic          i_rx_active,
  output logic          o_rx_ready,
  output logic [7:0]    o_data,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [AW:0]   o_fill,
  output logic          o_overflow,
  output logic          o_hs_err,
  input  logic          i_clear_err,
  output logic          o_busy
`ifdef UART_RX_CTRL_STATS_EN
  ,
  output logic [15:0]   o_drop_cnt
`endif
);
  state_t        r_state, w_next;
  logic [TW-1:0] r_cnt, w_cnt_next;
  logic          w_full, w_empty, w_pop, w_push, w_drop, w_hs_to;
  assign o_valid    = !w_empty;
  assign w_pop      = o_valid && i_ready;
  assign o_rx_ready = r_state == ST_WAIT;
  assign o_busy     = i_rx_active || (r_state != ST_IDLE);
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_push     = 1'b0;
    w_drop     = 1'b0;
    w_hs_to    = 1'b0;
    case (r_state)
      ST_IDLE: w_next = i_rx_valid ? ST_CAPTURE : ST_IDLE;
      ST_CAPTURE: begin
        w_push     = !w_full || w_pop;
        w_drop     = w_full && !w_pop;
        w_cnt_next = '0;
        w_next     = ST_WAIT;
      end
      ST_WAIT:
        if (!i_rx_valid) w_next = ST_RELEASE;
        else if (r_cnt == TW'(HS_TIMEOUT - 1)) begin
          w_hs_to = 1'b1;
          w_next  = ST_RELEASE;
        end else w_cnt_next = r_cnt + TW'(1);
      // hold ready low until valid drops so the same byte is never re-captured
      ST_RELEASE: w_next = i_rx_valid ? ST_RELEASE : ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end
  always_ff @(posedge i_uart_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      o_overflow <= 1'b0;
      o_hs_err   <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_cnt      <= w_cnt_next;
      o_overflow <= w_drop || (o_overflow && !i_clear_err);
      o_hs_err   <= w_hs_to || (o_hs_err && !i_clear_err);
    end
`ifdef UART_RX_CTRL_STATS_EN
  always_ff @(posedge i_uart_clk or negedge i_rst_n)
    if (!i_rst_n) o_drop_cnt <= '0;
    else if (w_drop) o_drop_cnt <= i_clear_err ? 16'd1 : (o_drop_cnt == 16'hFFFF ? o_drop_cnt : o_drop_cnt + 16'd1);
    else if (i_clear_err) o_drop_cnt <= '0;
`endif
  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (i_uart_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (i_rx_byte),
    .o_data  (o_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_fill  (o_fill)
  );
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: scoreboard bench driving the uart_rx handshake directly.
module tb_uart_rx_ctrl;
  localparam int DEPTH = 16;
  localparam int HS_TIMEOUT = 1023;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic rx_valid = 1'b0, rx_active = 1'b0, rdy = 1'b0, clear_err = 1'b0;
  logic o_rx_ready, o_valid, o_overflow, o_hs_err, o_busy;
  logic [7:0] o_data;
  logic [4:0] o_fill;
`ifdef UART_RX_CTRL_STATS_EN
  logic [15:0] o_drop_cnt;
`endif
  int n_vec = 0, n_err = 0;
  logic [7:0] q[$];
  int mfill = 0, mdrop = 0;
  bit movf = 0, mhs = 0;

  always #5 clk = ~clk;

  uart_rx_ctrl #(.DEPTH(DEPTH), .HS_TIMEOUT(HS_TIMEOUT)) dut (
    .i_uart_clk (clk),
    .i_rst_n    (rst_n),
    .i_rx_byte  (rx_byte),
    .i_rx_valid (rx_valid),
    .i_rx_active(rx_active),
    .o_rx_ready (o_rx_ready),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .i_ready    (rdy),
    .o_fill     (o_fill),
    .o_overflow (o_overflow),
    .o_hs_err   (o_hs_err),
    .i_clear_err(clear_err),
    .o_busy     (o_busy)
`ifdef UART_RX_CTRL_STATS_EN
    ,
    .o_drop_cnt (o_drop_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit pop_cap);
    int k;
    logic [7:0] e;
    @(negedge clk);
    rx_byte = b;
    rx_valid = 1'b1;
    @(negedge clk);
    if (pop_cap) begin
      e = (q.size() > 0) ? q.pop_front() : 8'h00;
      chk("cap_head", {24'h0, o_data}, {24'h0, e});
      mfill--;
      rdy = 1'b1;
    end
    if (mfill < DEPTH) begin
      q.push_back(b);
      mfill++;
    end else begin
      movf = 1'b1;
      mdrop++;
    end
    @(negedge clk);
    rdy = 1'b0;
    chk("fill_lat", 32'(o_fill), mfill);
    chk("valid_lat", 32'(o_valid), 32'(mfill != 0));
    k = 0;
    while (!o_rx_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("rdy_pulse", 32'(o_rx_ready), 1);
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rdy_low", 32'(o_rx_ready), 0);
    chk("ovf", 32'(o_overflow), 32'(movf));
    chk("idle", 32'(o_busy), 0);
  endtask

  task automatic pop_one();
    logic [7:0] e;
    @(negedge clk);
    e = (q.size() > 0) ? q.pop_front() : 8'h00;
    chk("pop_valid", 32'(o_valid), 1);
    chk("pop_data", {24'h0, o_data}, {24'h0, e});
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
    mfill--;
    chk("pop_fill", 32'(o_fill), mfill);
  endtask

  task automatic clear_flags();
    @(negedge clk);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    movf = 1'b0;
    mhs = 1'b0;
    mdrop = 0;
    chk("clr_ovf", 32'(o_overflow), 0);
    chk("clr_hs", 32'(o_hs_err), 0);
`ifdef UART_RX_CTRL_STATS_EN
    chk("clr_drop", 32'(o_drop_cnt), 0);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_rdy", 32'(o_rx_ready), 0);
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_data", 32'(o_data), 0);
    chk("rst_fill", 32'(o_fill), 0);
    chk("rst_flags", {30'h0, o_overflow, o_hs_err}, 0);
    rst_n = 1'b1;
    rx_active = 1'b1;
    @(negedge clk);
    chk("busy_active", 32'(o_busy), 1);
    rx_active = 1'b0;
    // single byte, consumer stalled
    send_byte(8'hA5, 1'b0);
    chk("t1_data", 32'(o_data), 32'hA5);
    chk("t1_hs", 32'(o_hs_err), 0);
    pop_one();
    chk("t1_empty", 32'(o_valid), 0);
    // sixteen back-to-back bytes then drain
    for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b0);
    chk("t2_full", 32'(o_fill), 16);
    for (int i = 0; i < 16; i++) pop_one();
    chk("t2_empty", 32'(o_valid), 0);
    // overflow on the seventeenth byte
    for (int i = 0; i < 17; i++) send_byte(8'(i), 1'b0);
    chk("t3_ovf", 32'(o_overflow), 1);
    chk("t3_fill", 32'(o_fill), 16);
    chk("t3_head", 32'(o_data), 0);
`ifdef UART_RX_CTRL_STATS_EN
    chk("t3_drop", 32'(o_drop_cnt), 32'(mdrop));
`endif
    clear_flags();
    // pop exactly in the capture cycle of a full FIFO
    send_byte(8'h77, 1'b1);
    chk("t4_fill", 32'(o_fill), 16);
    chk("t4_ovf", 32'(o_overflow), 0);
    for (int i = 0; i < 16; i++) pop_one();
    // stuck valid forces a handshake timeout
    @(negedge clk);
    rx_byte = 8'h3C;
    rx_valid = 1'b1;
    repeat (HS_TIMEOUT + 1) @(negedge clk);
    chk("t5_hs_pre", 32'(o_hs_err), 0);
    chk("t5_rdy_pre", 32'(o_rx_ready), 1);
    @(negedge clk);
    q.push_back(8'h3C);
    mfill++;
    mhs = 1'b1;
    chk("t5_hs", 32'(o_hs_err), 32'(mhs));
    chk("t5_rdy", 32'(o_rx_ready), 0);
    repeat (5) @(negedge clk);
    chk("t5_release", 32'(o_busy), 1);
    chk("t5_one_push", 32'(o_fill), mfill);
    rx_valid = 1'b0;
    @(negedge clk);
    chk("t5_idle", 32'(o_busy), 0);
    pop_one();
    clear_flags();
    // async reset while waiting for valid to drop
    @(negedge clk);
    rx_byte = 8'hEE;
    rx_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("t6_inwait", 32'(o_rx_ready), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rdy", 32'(o_rx_ready), 0);
    chk("t6_valid", 32'(o_valid), 0);
    chk("t6_fill", 32'(o_fill), 0);
    chk("t6_busy", 32'(o_busy), 0);
    q.delete();
    mfill = 0;
    @(negedge clk);
    rx_valid = 1'b0;
    rst_n = 1'b1;
    send_byte(8'h5A, 1'b0);
    pop_one();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
